// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-MM RAM responder.
// Provides the bus data/byte-enable widths and the transfer FSM state type.
package avalon_pkg;

    localparam int unsigned AVL_DATA_W = 32;
    localparam int unsigned AVL_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } avl_state_t;

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM with per-byte write lanes.
// Ports:
//   clk         rising-edge clock
//   we, be      write enable and 4-bit lane mask (bit i -> bits [8i+7:8i])
//   waddr/wdata synchronous write port
//   re, raddr   synchronous read port; rdata updates only when re=1
//   rdata       registered read data (read-before-write on a shared address)
module byte_lane_ram
    import avalon_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AVL_BE_W-1:0]   be,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [AVL_DATA_W-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [AVL_DATA_W-1:0] rdata
);

    logic [AVL_DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(AVL_BE_W); i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/avalon_ram_responder.sv
// Avalon-MM slave memory with programmable wait states and a preload port.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   address/read/write         master request (address bits [1:0] ignored)
//   writedata/byteenable       write data and lane enables, sampled live in ACK
//   waitrequest                high while the transfer is not accepted
//   readdata                   read data, valid while read=1 and waitrequest=0
//   inst_input/inst_addr/      preload port: full-word write at inst_addr
//   instruction                (byte address relative to BASE_ADDR)
//   range_err                  one-cycle pulse on an out-of-range completion
module avalon_ram_responder
    import avalon_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned LOAD_AW     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [AVL_DATA_W-1:0] writedata,
    input  logic [AVL_BE_W-1:0]   byteenable,
    output logic                  waitrequest,
    output logic [AVL_DATA_W-1:0] readdata,
    input  logic                  inst_input,
    input  logic [LOAD_AW-1:0]    inst_addr,
    input  logic [AVL_DATA_W-1:0] instruction,
    output logic                  range_err
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

    avl_state_t          state_q, state_d;
    logic [3:0]          counter_q, counter_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                in_range_q, in_range_d;
    logic                rd_valid_q;
    logic                range_err_q;
    logic                enter_ack;

    // Address decode
    logic [31:0]         off;
    logic [ADDR_W-1:0]   idx;
    logic                in_range;
    logic                req;

    assign off      = address - BASE_ADDR;
    assign idx      = off[ADDR_W+1:2];
    assign in_range = (off >> (ADDR_W + 2)) == 32'd0;
    assign req      = read | write;

    logic [31:0]         load_off;
    logic [ADDR_W-1:0]   load_idx;
    assign load_off = {{(32 - LOAD_AW){1'b0}}, inst_addr};
    assign load_idx = load_off[ADDR_W+1:2];

    logic unused_ok;
    assign unused_ok = ^{off[1:0], load_off};

    always_comb begin
        state_d    = state_q;
        counter_d  = counter_q;
        idx_d      = idx_q;
        in_range_d = in_range_q;
        enter_ack  = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending preload holds off new transfers from IDLE only.
                if (!inst_input && req) begin
                    idx_d      = idx;
                    in_range_d = in_range;
                    counter_d  = WAIT_CNT;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;  // master dropped the request: abandon it
                end else if (counter_q == 4'd1) begin
                    state_d   = ACK;
                    enter_ack = 1'b1;
                end else begin
                    counter_d = counter_q - 4'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The IDLE->ACK path (no wait states) must use the live decode.
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_in_range;
    assign rd_idx      = (state_q == IDLE) ? idx : idx_q;
    assign rd_in_range = (state_q == IDLE) ? in_range : in_range_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            counter_q   <= 4'd0;
            idx_q       <= '0;
            in_range_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            idx_q       <= idx_d;
            in_range_q  <= in_range_d;
            range_err_q <= enter_ack && !rd_in_range;
            if (enter_ack) begin
                rd_valid_q <= rd_in_range;
            end
        end
    end

    // Single write port: a preload takes priority over the ACK write in the
    // same cycle, so a concurrent bus write is dropped.
    logic                  ack_we;
    logic                  ram_we;
    logic [AVL_BE_W-1:0]   ram_be;
    logic [ADDR_W-1:0]     ram_waddr;
    logic [AVL_DATA_W-1:0] ram_wdata;
    logic [AVL_DATA_W-1:0] ram_rdata;

    assign ack_we    = (state_q == ACK) && write && in_range_q && !reset;
    assign ram_we    = inst_input | ack_we;
    assign ram_be    = inst_input ? {AVL_BE_W{1'b1}} : byteenable;
    assign ram_waddr = inst_input ? load_idx : idx_q;
    assign ram_wdata = inst_input ? instruction : writedata;

    byte_lane_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (ram_be),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (enter_ack),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

    // RAM output register has no reset; gate it so readdata is 0 after reset
    // and after an out-of-range read.
    assign readdata    = rd_valid_q ? ram_rdata : '0;
    assign waitrequest = (state_q != ACK);
    assign range_err   = range_err_q;

endmodule

// File: tb/tb_avalon_ram_responder.sv
module tb_avalon_ram_responder;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // Instance with two wait states
    logic [31:0] address;
    logic        read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        inst_input;
    logic [7:0]  inst_addr;
    logic [31:0] instruction;
    logic        range_err;

    // Instance with zero wait states
    logic [31:0] address0;
    logic        read0;
    logic        waitrequest0;
    logic [31:0] readdata0;
    logic        inst_input0;
    logic [7:0]  inst_addr0;
    logic [31:0] instruction0;
    logic        range_err0;

    int n_tests = 0;
    int n_fail  = 0;

    avalon_ram_responder #(
        .ADDR_W      (8),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (2),
        .LOAD_AW     (8)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .inst_input  (inst_input),
        .inst_addr   (inst_addr),
        .instruction (instruction),
        .range_err   (range_err)
    );

    avalon_ram_responder #(
        .ADDR_W      (8),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (0),
        .LOAD_AW     (8)
    ) u_dut0 (
        .clk         (clk),
        .reset       (reset),
        .address     (address0),
        .read        (read0),
        .write       (1'b0),
        .writedata   (32'h0),
        .byteenable  (4'h0),
        .waitrequest (waitrequest0),
        .readdata    (readdata0),
        .inst_input  (inst_input0),
        .inst_addr   (inst_addr0),
        .instruction (instruction0),
        .range_err   (range_err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        inst_input  = 1'b1;
        inst_addr   = a;
        instruction = d;
        tick();
        inst_input  = 1'b0;
    endtask

    // Runs one transfer on u_dut; lat counts stalled cycles before acceptance.
    task automatic xfer(input logic is_wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd, output int lat,
                        output logic rerr);
        address    = a;
        writedata  = wd;
        byteenable = be;
        read       = !is_wr;
        write      = is_wr;
        lat        = 0;
        rd         = 'x;
        rerr       = 1'bx;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!waitrequest) begin
                rd   = readdata;
                rerr = range_err;
                break;
            end
            lat++;
        end
        tick();
        read  = 1'b0;
        write = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;
    logic        rerr;

    initial begin
        reset = 1'b1;
        address = '0; read = 0; write = 0; writedata = '0; byteenable = '0;
        inst_input = 0; inst_addr = '0; instruction = '0;
        address0 = '0; read0 = 0; inst_input0 = 0; inst_addr0 = '0; instruction0 = '0;
        tick();
        tick();
        @(negedge clk);
        check("reset_waitrequest", {31'd0, waitrequest}, 32'd1);
        check("reset_readdata", readdata, 32'h0);
        check("reset_range_err", {31'd0, range_err}, 32'd0);
        tick();
        reset = 1'b0;

        preload(8'h00, 32'h0000_0000);
        preload(8'h0C, 32'h0000_0000);

        // Preload then read
        preload(8'h04, 32'h2403_0FF0);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, lat, rerr);
        check("t1_latency", lat, 32'd3);
        check("t1_data", rd, 32'h2403_0FF0);
        check("t1_range_err", {31'd0, rerr}, 32'd0);

        // Byte-enabled write
        preload(8'h08, 32'h1234_5678);
        xfer(1'b1, 32'h08, 32'hDEAD_BEEF, 4'b0011, rd, lat, rerr);
        check("t2_wr_latency", lat, 32'd3);
        xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, lat, rerr);
        check("t2_data", rd, 32'h1234_BEEF);

        // Last in-range word
        xfer(1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hF, rd, lat, rerr);
        check("top_word_wr_err", {31'd0, rerr}, 32'd0);
        xfer(1'b0, 32'h3FC, 32'h0, 4'h0, rd, lat, rerr);
        check("top_word_data", rd, 32'hCAFE_F00D);

        // Out of range
        xfer(1'b0, 32'h400, 32'h0, 4'h0, rd, lat, rerr);
        check("t3_rd_data", rd, 32'h0);
        check("t3_rd_err", {31'd0, rerr}, 32'd1);
        check("t3_rd_latency", lat, 32'd3);
        @(negedge clk);
        check("t3_err_pulse_end", {31'd0, range_err}, 32'd0);
        tick();
        xfer(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, rd, lat, rerr);
        check("t3_wr_err", {31'd0, rerr}, 32'd1);
        xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, lat, rerr);
        check("t3_word0_kept", rd, 32'h0);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, lat, rerr);
        check("t3_word1_kept", rd, 32'h2403_0FF0);

        // Preload stall: request held while preloading
        inst_input  = 1'b1;
        inst_addr   = 8'h10;
        instruction = 32'h1111_1111;
        address     = 32'h04;
        read        = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_stall_wait", {31'd0, waitrequest}, 32'd1);
            tick();
        end
        inst_input = 1'b0;
        xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, lat, rerr);
        check("t4_latency", lat, 32'd3);
        check("t4_data", rd, 32'h2403_0FF0);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, lat, rerr);
        check("t4_preload_data", rd, 32'h1111_1111);

        // Reset during WAIT of a write
        address    = 32'h0C;
        writedata  = 32'hFFFF_FFFF;
        byteenable = 4'hF;
        write      = 1'b1;
        tick();
        @(negedge clk);
        check("t5_in_wait", {31'd0, waitrequest}, 32'd1);
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("t5_no_ack", {31'd0, waitrequest}, 32'd1);
        tick();
        write = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("t5_after_reset", {31'd0, waitrequest}, 32'd1);
        tick();
        xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd, lat, rerr);
        check("t5_data", rd, 32'h0);

        // Zero wait states, back-to-back reads
        inst_input0 = 1'b1; inst_addr0 = 8'h04; instruction0 = 32'h0BAD_F00D;
        tick();
        inst_addr0 = 8'h08; instruction0 = 32'h600D_CAFE;
        tick();
        inst_input0 = 1'b0;
        address0 = 32'h04;
        read0    = 1'b1;
        @(negedge clk);
        check("t6_a_issue_wait", {31'd0, waitrequest0}, 32'd1);
        tick();
        @(negedge clk);
        check("t6_a_ack", {31'd0, waitrequest0}, 32'd0);
        check("t6_a_data", readdata0, 32'h0BAD_F00D);
        tick();
        address0 = 32'h08;
        @(negedge clk);
        check("t6_b_issue_wait", {31'd0, waitrequest0}, 32'd1);
        tick();
        @(negedge clk);
        check("t6_b_ack", {31'd0, waitrequest0}, 32'd0);
        check("t6_b_data", readdata0, 32'h600D_CAFE);
        tick();
        read0 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
